// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one single-cycle ALU between the execute stage (req0)
// and the branch/address unit (req1), with a held response register per requester.
module alu_share_arbiter #(
  parameter int width = 32
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_dataA,
  input  logic [width-1:0] req0_dataB,
  input  logic [3:0]       req0_func,
  input  logic [2:0]       req0_aluOp,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_dataA,
  input  logic [width-1:0] req1_dataB,
  input  logic [3:0]       req1_func,
  input  logic [2:0]       req1_aluOp,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [width-1:0] rsp0_result,
  output logic             rsp0_branch,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [width-1:0] rsp1_result,
  output logic             rsp1_branch,

  output logic [width-1:0] alu_dataA,
  output logic [width-1:0] alu_dataB,
  output logic [3:0]       alu_func,
  output logic [2:0]       alu_aluOp,
  input  logic [width-1:0] aluResult,
  input  logic             branchFromAlu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic             r_owner;
  logic             r_last_grant;

  logic [width-1:0] r_alu_dataA;
  logic [width-1:0] r_alu_dataB;
  logic [3:0]       r_alu_func;
  logic [2:0]       r_alu_aluOp;

  logic             r_rsp0_valid;
  logic [width-1:0] r_rsp0_result;
  logic             r_rsp0_branch;
  logic             r_rsp1_valid;
  logic [width-1:0] r_rsp1_result;
  logic             r_rsp1_branch;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_rsp_take;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (w_rsp_take) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Grants only in IDLE; on a tie the requester that did not win last time goes
  always_comb begin
    w_grant0   = 1'b0;
    w_grant1   = 1'b0;
    w_rsp_take = 1'b0;
    if (r_state == IDLE) begin
      w_grant0 = req0_valid & (~req1_valid | r_last_grant);
      w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    end
    if (r_state == RESP) begin
      w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;
    end
  end

  assign w_accept   = w_grant0 | w_grant1;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Operand latch, ownership and response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_alu_dataA   <= '0;
      r_alu_dataB   <= '0;
      r_alu_func    <= '0;
      r_alu_aluOp   <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_branch <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_branch <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant1) begin
            r_alu_dataA  <= req1_dataA;
            r_alu_dataB  <= req1_dataB;
            r_alu_func   <= req1_func;
            r_alu_aluOp  <= req1_aluOp;
            r_owner      <= 1'b1;
            r_last_grant <= 1'b1;
          end else if (w_grant0) begin
            r_alu_dataA  <= req0_dataA;
            r_alu_dataB  <= req0_dataB;
            r_alu_func   <= req0_func;
            r_alu_aluOp  <= req0_aluOp;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
          end
        end
        EXEC: begin
          if (r_owner) begin
            r_rsp1_result <= aluResult;
            r_rsp1_branch <= branchFromAlu;
            r_rsp1_valid  <= 1'b1;
          end else begin
            r_rsp0_result <= aluResult;
            r_rsp0_branch <= branchFromAlu;
            r_rsp0_valid  <= 1'b1;
          end
        end
        RESP: begin
          if (w_rsp_take) begin
            if (r_owner) r_rsp1_valid <= 1'b0;
            else         r_rsp0_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_dataA   = r_alu_dataA;
  assign alu_dataB   = r_alu_dataB;
  assign alu_func    = r_alu_func;
  assign alu_aluOp   = r_alu_aluOp;

  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_branch = r_rsp0_branch;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_branch = r_rsp1_branch;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU drives aluResult, and a per-cycle
// reference model of the sharing rules checks every output.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_dataA, req0_dataB, req1_dataA, req1_dataB;
  logic [3:0]   req0_func, req1_func;
  logic [2:0]   req0_aluOp, req1_aluOp;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         rsp0_branch, rsp1_branch;
  logic [W-1:0] alu_dataA, alu_dataB, aluResult;
  logic [3:0]   alu_func;
  logic [2:0]   alu_aluOp;
  logic         branchFromAlu;

  always #5 clock = ~clock;

  // Behavioural ALU: {branch, result}
  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] f, input logic [2:0] op);
    logic [W-1:0] res;
    logic         br;
    res = '0;
    case (op)
      3'd0: res = a + b;
      3'd2: case (f[2:0])
              3'd0: res = f[3] ? a - b : a + b;
              3'd1: res = a << b[4:0];
              3'd4: res = a ^ b;
              3'd6: res = a | b;
              3'd7: res = a & b;
              default: res = '0;
            endcase
      default: res = '0;
    endcase
    case (f[2:0])
      3'd0: br = (a == b);
      3'd1: br = (a != b);
      3'd4: br = ($signed(a) <  $signed(b));
      3'd5: br = ($signed(a) >= $signed(b));
      3'd6: br = (a <  b);
      3'd7: br = (a >= b);
      default: br = 1'b0;
    endcase
    return {br, res};
  endfunction

  always_comb {branchFromAlu, aluResult} = alu_fn(alu_dataA, alu_dataB, alu_func, alu_aluOp);

  alu_share_arbiter #(.width(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dataA(req0_dataA),
    .req0_dataB(req0_dataB), .req0_func(req0_func), .req0_aluOp(req0_aluOp),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dataA(req1_dataA),
    .req1_dataB(req1_dataB), .req1_func(req1_func), .req1_aluOp(req1_aluOp),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_branch(rsp0_branch),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_branch(rsp1_branch),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_func(alu_func),
    .alu_aluOp(alu_aluOp), .aluResult(aluResult), .branchFromAlu(branchFromAlu)
  );

  // Reference model: phase 0 = free, 1 = ALU busy, 2 = holding a response
  int           m_phase;
  logic         m_last, m_owner;
  logic         m_v[2];
  logic [W-1:0] m_res[2];
  logic         m_br[2];
  logic [W-1:0] m_a, m_b;
  logic [3:0]   m_f;
  logic [2:0]   m_op;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int grants[$];
  int gcyc[$];

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = 1'b1; m_owner = 1'b0;
    m_a = '0; m_b = '0; m_f = '0; m_op = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_res[i] = '0; m_br[i] = 1'b0;
    end
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge
  task automatic cyc();
    logic e0, e1;
    logic [W:0] r;
    #1;
    e0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
    e1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp0_valid", rsp0_valid, m_v[0]);
    chk("rsp1_valid", rsp1_valid, m_v[1]);
    if (m_v[0]) begin
      chk("rsp0_result", rsp0_result, m_res[0]);
      chk("rsp0_branch", rsp0_branch, m_br[0]);
    end
    if (m_v[1]) begin
      chk("rsp1_result", rsp1_result, m_res[1]);
      chk("rsp1_branch", rsp1_branch, m_br[1]);
    end
    chk("alu_dataA", alu_dataA, m_a);
    chk("alu_dataB", alu_dataB, m_b);
    chk("alu_func",  alu_func,  m_f);
    chk("alu_aluOp", alu_aluOp, m_op);
    if (req0_ready === 1'b1) begin grants.push_back(0); gcyc.push_back(cyc_n); end
    if (req1_ready === 1'b1) begin grants.push_back(1); gcyc.push_back(cyc_n); end

    if (reset) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (e0 || e1) begin
        m_owner = e1;
        m_last  = e1;
        m_a  = e1 ? req1_dataA : req0_dataA;
        m_b  = e1 ? req1_dataB : req0_dataB;
        m_f  = e1 ? req1_func  : req0_func;
        m_op = e1 ? req1_aluOp : req0_aluOp;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      r = alu_fn(m_a, m_b, m_f, m_op);
      m_res[m_owner] = r[W-1:0];
      m_br[m_owner]  = r[W];
      m_v[m_owner]   = 1'b1;
      m_phase = 2;
    end else begin
      if (m_owner ? rsp1_ready : rsp0_ready) begin
        m_v[m_owner] = 1'b0;
        m_phase = 0;
      end
    end
    cyc_n++;
    @(posedge clock);
    #1;
  endtask

  task automatic rand_ops();
    req0_dataA = $urandom; req0_dataB = $urandom;
    req1_dataA = $urandom; req1_dataB = $urandom;
    req0_func  = 4'($urandom_range(0, 15)); req1_func  = 4'($urandom_range(0, 15));
    req0_aluOp = 3'($urandom_range(0, 7));  req1_aluOp = 3'($urandom_range(0, 7));
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_dataA = '0; req0_dataB = '0; req0_func = '0; req0_aluOp = '0;
    req1_dataA = '0; req1_dataB = '0; req1_func = '0; req1_aluOp = '0;
    @(posedge clock);
    #1;
    model_reset();
    cyc();
    reset = 1'b0;
    chk("reset_rsp0_result", rsp0_result, '0);
    chk("reset_rsp1_result", rsp1_result, '0);
    chk("reset_rsp0_branch", rsp0_branch, 1'b0);
    cyc();

    // Single request: 5 + 3
    req0_valid = 1'b1; req0_dataA = 32'd5; req0_dataB = 32'd3; req0_func = 4'd0; req0_aluOp = 3'd2;
    rsp0_ready = 1'b1;
    cyc();
    req0_valid = 1'b0;
    cyc();
    chk("add_valid",  rsp0_valid,  1'b1);
    chk("add_result", rsp0_result, 32'd8);
    chk("add_branch", rsp0_branch, 1'b0);
    chk("add_rsp1",   rsp1_valid,  1'b0);
    cyc();
    cyc();

    // Subtract with equal-compare branch on requester 1
    req1_valid = 1'b1; req1_dataA = 32'd7; req1_dataB = 32'd7; req1_func = 4'b1000; req1_aluOp = 3'd2;
    rsp1_ready = 1'b1;
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk("sub_result", rsp1_result, 32'd0);
    chk("sub_branch", rsp1_branch, 1'b1);
    chk("sub_valid",  rsp1_valid,  1'b1);
    cyc();

    // Tie after reset: grants alternate 0,1,0,1 three cycles apart
    reset = 1'b1; cyc(); reset = 1'b0;
    grants.delete(); gcyc.delete();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      rand_ops();
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      chk("tie_order", grants[i], i % 2);
      if (i > 0) chk("tie_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    cyc(); cyc();

    // Backpressure on requester 0
    req0_valid = 1'b1; req0_dataA = 32'h1234; req0_dataB = 32'h0F0F; req0_func = 4'd4; req0_aluOp = 3'd2;
    rsp0_ready = 1'b0;
    cyc();
    req0_valid = 1'b0;
    cyc();
    req1_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      cyc();
      chk("bp_result", rsp0_result, 32'h1234 ^ 32'h0F0F);
    end
    rsp0_ready = 1'b1;
    cyc();
    chk("bp_drop", rsp0_valid, 1'b0);
    cyc();
    req1_valid = 1'b0;
    cyc(); cyc();

    // Reset while the operation is in EXEC
    req0_valid = 1'b1; req0_dataA = 32'd9; req0_dataB = 32'd4; req0_func = 4'd0; req0_aluOp = 3'd0;
    cyc();
    req0_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int unsigned i = 0; i < 4; i++) cyc();
    chk("rst_exec_rsp0", rsp0_valid, 1'b0);
    chk("rst_exec_res0", rsp0_result, '0);
    chk("rst_exec_alu",  alu_dataA, '0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_exec_tie", req0_ready, 1'b1);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(); cyc(); cyc();

    // Unsupported opcode
    req1_valid = 1'b1; req1_dataA = 32'd1; req1_dataB = 32'd1; req1_func = 4'd0; req1_aluOp = 3'b111;
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk("unsup_result", rsp1_result, '0);
    chk("unsup_branch", rsp1_branch, 1'b1);
    cyc(); cyc();

    // Randomized traffic with occasional reset
    for (int unsigned i = 0; i < 400; i++) begin
      rand_ops();
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
